game_load_seq: RTL

GAME_LOAD_SEQ -- requirements
Module: game_load_seq

---
 rtl/game_load_seq_pkg.sv | 15 +
 rtl/game_load_seq_oled_xy_map.sv | 52 +++++
 rtl/game_load_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/game_load_seq_pkg.sv
// Shared encodings and screen geometry for the loading-screen sequencer.
package game_load_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LOAD_SEGMENTS = 4;
  localparam int OLED_W        = 96;
  localparam int OLED_H        = 64;
  localparam int OLED_PIXELS   = OLED_W * OLED_H;

endpackage

// File: rtl/game_load_seq_oled_xy_map.sv
// Maps an OLED raster index to a registered (column, row) pair, one cycle latency.
// Out-of-range indices map to the origin.
module oled_xy_map
  import game_load_seq_pkg::*;
#(
  parameter int SCREEN_W = OLED_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  output logic [6:0]  x,
  output logic [5:0]  y
);

  localparam logic [13:0] PIX_LIM = 14'(SCREEN_W * OLED_H);
  localparam logic [13:0] W14     = 14'(SCREEN_W);

  // Restoring long division by the constant width: 6 quotient bits cover 64 rows.
  function automatic logic [12:0] div_w(input logic [12:0] p);
    logic [13:0] rem;
    logic [5:0]  q;
    rem = {1'b0, p};
    q   = '0;
    for (int i = 5; i >= 0; i--) begin
      if (rem >= (W14 << i)) begin
        rem  = rem - (W14 << i);
        q[i] = 1'b1;
      end
    end
    return {q, rem[6:0]};
  endfunction

  logic        in_range;
  logic [12:0] qr;

  assign in_range = {1'b0, pixel_index} < PIX_LIM;
  assign qr       = div_w(pixel_index);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (in_range) begin
      x <= qr[6:0];
      y <= qr[12:7];
    end else begin
      x <= '0;
      y <= '0;
    end
  end

endmodule

// File: rtl/game_load_seq.sv
// Loading-bar sequencer: lights four segments of STEP_TICKS unpaused cycles each,
// pulses done when the last one expires; abort returns to IDLE from anywhere.
module game_load_seq
  import game_load_seq_pkg::*;
#(
  parameter int STEP_TICKS = 6250000,
  parameter int SCREEN_W   = OLED_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        abort,
  input  logic [12:0] pixel_index,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [2:0]  cnt,
  output logic        busy,
  output logic        done
);

  localparam int            TW      = $clog2(STEP_TICKS);
  localparam logic [TW-1:0] T_LAST  = TW'(STEP_TICKS - 1);
  localparam logic [2:0]    CNT_MAX = 3'(LOAD_SEGMENTS);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          seg_end;

  assign seg_end = (state == ST_LOAD) && !pause && (timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_LOAD;
        ST_LOAD: if (seg_end && cnt == CNT_MAX) state_nxt = ST_DONE;
        ST_DONE: if (start) state_nxt = ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_LOAD);
  end

  // Segment timer, lit-segment count and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        timer <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              cnt   <= 3'd1;
              timer <= '0;
            end
          end
          ST_LOAD: begin
            if (seg_end) begin
              timer <= '0;
              if (cnt == CNT_MAX) done <= 1'b1;
              else                cnt  <= cnt + 3'd1;
            end else if (!pause) begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            timer <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  oled_xy_map #(.SCREEN_W(SCREEN_W)) u_xy (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y)
  );

endmodule
